// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 interrupt controller:
// cp0 register numbers, interrupt width and the derived service state.
package cp0_pkg;

    localparam int NUM_IRQ = 3;
    localparam int IDX_W   = 2;

    localparam logic [4:0] CP0_STAT = 5'h0d;
    localparam logic [4:0] CP0_EPC  = 5'h0e;
    localparam logic [4:0] CP0_DIS  = 5'h16;
    localparam logic [4:0] CP0_MASK = 5'h17;

    // Service state mirrors whether any handler is in service (isr != 0).
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SVC  = 1'b1
    } cp0_state_e;

    // One-hot select for an interrupt index.
    function automatic logic [NUM_IRQ-1:0] irq_onehot(input logic [IDX_W-1:0] idx);
        return NUM_IRQ'(1) << idx;
    endfunction

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// Pipeline-facing signal bundle of the cp0 interrupt controller.
// master = CPU/IO side, slave = the controller itself.
interface cp0_int_ctrl_if;
    import cp0_pkg::*;

    logic [NUM_IRQ-1:0] irq_in;
    logic               take_ok;
    logic [31:0]        pc_resume;
    logic               eret;
    logic               mtc0_we;
    logic [4:0]         mtc0_addr;
    logic [31:0]        mtc0_data;
    logic [4:0]         mfc0_addr;
    logic [31:0]        mfc0_data;
    logic               int_take;
    logic [31:0]        int_vector;
    logic               eret_redirect;
    logic [31:0]        epc_out;
    logic               int_disable;

    modport master (
        output irq_in, take_ok, pc_resume, eret,
        output mtc0_we, mtc0_addr, mtc0_data, mfc0_addr,
        input  mfc0_data, int_take, int_vector, eret_redirect, epc_out, int_disable
    );

    modport slave (
        input  irq_in, take_ok, pc_resume, eret,
        input  mtc0_we, mtc0_addr, mtc0_data, mfc0_addr,
        output mfc0_data, int_take, int_vector, eret_redirect, epc_out, int_disable
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Priority encoder: index of the highest set request bit plus a valid flag.
module irq_prio_enc
    import cp0_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic               vld,
    output logic [IDX_W-1:0]   idx
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        vld = |req;
        idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 interrupt controller: edge-detects IO interrupts, holds the
// disable/mask/EPC registers and an in-service bitmap for nesting, and
// decides when the pipeline is redirected to a handler or back to EPC.
module cp0_int_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] VEC2 = 32'h0000_0400,
    parameter logic [31:0] VEC1 = 32'h0000_0600,
    parameter logic [31:0] VEC0 = 32'h0000_0800
) (
    input  logic          clk,
    input  logic          rst,
    cp0_int_ctrl_if.slave bus
);

    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] isr_q;
    logic               disable_q;
    logic [31:0]        epc_q;
    cp0_state_e         state_q;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] isr_nxt;
    logic [NUM_IRQ-1:0] take_clr;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic               svc_vld;
    logic [IDX_W-1:0]   svc_idx;
    logic               qualify;
    logic               take;
    cp0_state_e         state_nxt;

    assign rise = bus.irq_in & ~irq_prev_q;
    assign elig = pending_q & mask_q & {NUM_IRQ{~disable_q}};

    irq_prio_enc u_enc_elig (
        .req (elig),
        .vld (win_vld),
        .idx (win_idx)
    );

    irq_prio_enc u_enc_isr (
        .req (isr_q),
        .vld (svc_vld),
        .idx (svc_idx)
    );

    // Take decision and next in-service bitmap; eret always beats a take.
    always_comb begin
        qualify  = win_vld && (!svc_vld || (win_idx > svc_idx));
        take     = qualify && bus.take_ok && !bus.eret;
        take_clr = take ? irq_onehot(win_idx) : '0;
        isr_nxt  = isr_q;
        if (take) begin
            isr_nxt = isr_q | irq_onehot(win_idx);
        end else if (bus.eret && state_q == ST_SVC) begin
            isr_nxt = isr_q & ~irq_onehot(svc_idx);
        end
    end

    // Service FSM next state: leaves SVC only when eret empties the bitmap.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (take) state_nxt = ST_SVC;
            ST_SVC:  if (bus.eret && isr_nxt == '0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Redirect outputs; the vector is only driven while a take is signalled.
    always_comb begin
        bus.int_take      = take;
        bus.eret_redirect = bus.eret;
        bus.int_vector    = '0;
        if (take) begin
            case (win_idx)
                2'd2:    bus.int_vector = VEC2;
                2'd1:    bus.int_vector = VEC1;
                default: bus.int_vector = VEC0;
            endcase
        end
    end

    // cp0 read port: reflects register state before any same-cycle write.
    always_comb begin
        bus.mfc0_data = '0;
        case (bus.mfc0_addr)
            CP0_DIS:  bus.mfc0_data = {31'b0, disable_q};
            CP0_MASK: bus.mfc0_data = {{(32-NUM_IRQ){1'b0}}, mask_q};
            CP0_EPC:  bus.mfc0_data = epc_q;
            CP0_STAT: bus.mfc0_data = {{(32-2*NUM_IRQ){1'b0}}, isr_q, pending_q};
            default:  bus.mfc0_data = '0;
        endcase
    end

    assign bus.epc_out     = epc_q;
    assign bus.int_disable = disable_q;

    // Edge detection, pending capture, in-service bitmap and FSM state.
    // A rise on the taken bit in the same cycle keeps it pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            isr_q      <= '0;
            state_q    <= ST_IDLE;
        end else begin
            irq_prev_q <= bus.irq_in;
            pending_q  <= (pending_q & ~take_clr) | rise;
            isr_q      <= isr_nxt;
            state_q    <= state_nxt;
        end
    end

    // Software-visible registers: take beats eret beats an mtc0 write.
    always_ff @(posedge clk) begin
        if (rst) begin
            disable_q <= 1'b1;
            mask_q    <= '0;
            epc_q     <= '0;
        end else begin
            if (take) begin
                disable_q <= 1'b1;
            end else if (bus.eret) begin
                disable_q <= (isr_nxt != '0);
            end else if (bus.mtc0_we && bus.mtc0_addr == CP0_DIS) begin
                disable_q <= bus.mtc0_data[0];
            end

            if (bus.mtc0_we && bus.mtc0_addr == CP0_MASK) begin
                mask_q <= bus.mtc0_data[NUM_IRQ-1:0];
            end

            if (take) begin
                epc_q <= bus.pc_resume;
            end else if (bus.mtc0_we && bus.mtc0_addr == CP0_EPC) begin
                epc_q <= bus.mtc0_data;
            end
        end
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed bench for cp0_int_ctrl: a per-cycle vector table plus
// hand-written sequences for stalled takes, eret collisions and reset.
module tb_cp0_int_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cp0_int_ctrl_if bus ();

    cp0_int_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  irq;
        logic        tok;
        logic        er;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [31:0] pc;
        logic        e_take;
        logic [31:0] e_vec;
        logic        e_ret;
        logic [31:0] e_rd;
        logic [31:0] e_epc;
        logic        e_dis;
    } vec_t;

    vec_t tbl [26];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] irq, input logic tok, input logic er,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [31:0] pc);
        bus.irq_in    = irq;
        bus.take_ok   = tok;
        bus.eret      = er;
        bus.mtc0_we   = we;
        bus.mtc0_addr = wa;
        bus.mtc0_data = wd;
        bus.mfc0_addr = ra;
        bus.pc_resume = pc;
    endtask

    // Sample on the falling edge, then advance past the next rising edge.
    task automatic step(input string tag, input logic e_take, input logic [31:0] e_vec,
                        input logic e_ret, input logic [31:0] e_rd,
                        input logic [31:0] e_epc, input logic e_dis);
        @(negedge clk);
        chk({tag, ".int_take"}, 32'(bus.int_take), 32'(e_take));
        chk({tag, ".int_vector"}, bus.int_vector, e_vec);
        chk({tag, ".eret_redirect"}, 32'(bus.eret_redirect), 32'(e_ret));
        chk({tag, ".mfc0_data"}, bus.mfc0_data, e_rd);
        chk({tag, ".epc_out"}, bus.epc_out, e_epc);
        chk({tag, ".int_disable"}, 32'(bus.int_disable), 32'(e_dis));
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           irq  tok er we wa     wd            ra     pc        take vec       ret rd     epc       dis
        tbl[0]  = '{3'd0, 0, 0, 0, 5'h00, 32'h0,        5'h16, 32'h0,    0, 32'h0,   0, 32'h1,  32'h0,   1};
        tbl[1]  = '{3'd0, 0, 0, 1, 5'h17, 32'h1,        5'h17, 32'h0,    0, 32'h0,   0, 32'h0,  32'h0,   1};
        tbl[2]  = '{3'd0, 0, 0, 1, 5'h16, 32'h0,        5'h16, 32'h0,    0, 32'h0,   0, 32'h1,  32'h0,   1};
        tbl[3]  = '{3'd1, 0, 0, 0, 5'h00, 32'h0,        5'h17, 32'h0,    0, 32'h0,   0, 32'h1,  32'h0,   0};
        tbl[4]  = '{3'd1, 1, 0, 0, 5'h00, 32'h0,        5'h0d, 32'h100,  1, 32'h800, 0, 32'h01, 32'h0,   0};
        tbl[5]  = '{3'd1, 1, 0, 0, 5'h00, 32'h0,        5'h0d, 32'h0,    0, 32'h0,   0, 32'h08, 32'h100, 1};
        tbl[6]  = '{3'd0, 0, 0, 0, 5'h00, 32'h0,        5'h0e, 32'h0,    0, 32'h0,   0, 32'h100,32'h100, 1};
        tbl[7]  = '{3'd0, 0, 1, 0, 5'h00, 32'h0,        5'h0d, 32'h0,    0, 32'h0,   1, 32'h08, 32'h100, 1};
        tbl[8]  = '{3'd0, 0, 0, 1, 5'h17, 32'h7,        5'h0d, 32'h0,    0, 32'h0,   0, 32'h00, 32'h100, 0};
        tbl[9]  = '{3'd3, 0, 0, 0, 5'h00, 32'h0,        5'h17, 32'h0,    0, 32'h0,   0, 32'h7,  32'h100, 0};
        tbl[10] = '{3'd3, 1, 0, 0, 5'h00, 32'h0,        5'h0d, 32'h200,  1, 32'h600, 0, 32'h03, 32'h100, 0};
        tbl[11] = '{3'd3, 1, 0, 0, 5'h00, 32'h0,        5'h0d, 32'h0,    0, 32'h0,   0, 32'h11, 32'h200, 1};
        tbl[12] = '{3'd0, 1, 0, 0, 5'h00, 32'h0,        5'h0d, 32'h0,    0, 32'h0,   0, 32'h11, 32'h200, 1};
        tbl[13] = '{3'd0, 1, 1, 0, 5'h00, 32'h0,        5'h0d, 32'h300,  0, 32'h0,   1, 32'h11, 32'h200, 1};
        tbl[14] = '{3'd0, 1, 0, 0, 5'h00, 32'h0,        5'h0d, 32'h300,  1, 32'h800, 0, 32'h01, 32'h200, 0};
        tbl[15] = '{3'd0, 0, 0, 0, 5'h00, 32'h0,        5'h0d, 32'h0,    0, 32'h0,   0, 32'h08, 32'h300, 1};
        tbl[16] = '{3'd0, 0, 0, 1, 5'h16, 32'h0,        5'h16, 32'h0,    0, 32'h0,   0, 32'h1,  32'h300, 1};
        tbl[17] = '{3'd4, 0, 0, 0, 5'h00, 32'h0,        5'h16, 32'h0,    0, 32'h0,   0, 32'h0,  32'h300, 0};
        tbl[18] = '{3'd4, 1, 0, 0, 5'h00, 32'h0,        5'h0d, 32'h344,  1, 32'h400, 0, 32'h0c, 32'h300, 0};
        tbl[19] = '{3'd4, 0, 0, 0, 5'h00, 32'h0,        5'h0d, 32'h0,    0, 32'h0,   0, 32'h28, 32'h344, 1};
        tbl[20] = '{3'd0, 0, 1, 0, 5'h00, 32'h0,        5'h0d, 32'h0,    0, 32'h0,   1, 32'h28, 32'h344, 1};
        tbl[21] = '{3'd0, 0, 0, 0, 5'h00, 32'h0,        5'h0d, 32'h0,    0, 32'h0,   0, 32'h08, 32'h344, 1};
        tbl[22] = '{3'd0, 0, 1, 0, 5'h00, 32'h0,        5'h0d, 32'h0,    0, 32'h0,   1, 32'h08, 32'h344, 1};
        tbl[23] = '{3'd0, 0, 0, 0, 5'h00, 32'h0,        5'h0d, 32'h0,    0, 32'h0,   0, 32'h00, 32'h344, 0};
        tbl[24] = '{3'd0, 0, 0, 1, 5'h05, 32'hffffffff, 5'h05, 32'h0,    0, 32'h0,   0, 32'h0,  32'h344, 0};
        tbl[25] = '{3'd0, 0, 0, 0, 5'h00, 32'h0,        5'h17, 32'h0,    0, 32'h0,   0, 32'h7,  32'h344, 0};

        rst = 1'b1;
        drive(3'd0, 0, 0, 0, 5'h00, 32'h0, 5'h00, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].irq, tbl[i].tok, tbl[i].er, tbl[i].we, tbl[i].wa,
                  tbl[i].wd, tbl[i].ra, tbl[i].pc);
            step($sformatf("row%0d", i), tbl[i].e_take, tbl[i].e_vec, tbl[i].e_ret,
                 tbl[i].e_rd, tbl[i].e_epc, tbl[i].e_dis);
        end

        // Stalled take: winner waits while take_ok is low, then is taken;
        // an mtc0 to disable in the take cycle loses to the take.
        drive(3'd1, 0, 0, 0, 5'h00, 32'h0, 5'h0d, 32'h0);
        step("stall.rise", 0, 32'h0, 0, 32'h00, 32'h344, 0);
        for (int i = 0; i < 3; i++) begin
            drive(3'd1, 0, 0, 0, 5'h00, 32'h0, 5'h0d, 32'h500 + 32'(i * 4));
            step($sformatf("stall.wait%0d", i), 0, 32'h0, 0, 32'h01, 32'h344, 0);
        end
        drive(3'd1, 1, 0, 1, 5'h16, 32'h0, 5'h0d, 32'h5a0);
        step("stall.take", 1, 32'h800, 0, 32'h01, 32'h344, 0);
        drive(3'd1, 0, 0, 0, 5'h00, 32'h0, 5'h0d, 32'h0);
        step("stall.after", 0, 32'h0, 0, 32'h08, 32'h5a0, 1);

        // eret collides with an mtc0 disable=1 (eret wins), then with a
        // qualifying winner (eret wins, take follows one cycle later).
        drive(3'd3, 0, 1, 1, 5'h16, 32'h1, 5'h0d, 32'h0);
        step("coll.eret_mtc0", 0, 32'h0, 1, 32'h08, 32'h5a0, 1);
        drive(3'd3, 1, 1, 0, 5'h00, 32'h0, 5'h0d, 32'h0);
        step("coll.eret_win", 0, 32'h0, 1, 32'h02, 32'h5a0, 0);
        drive(3'd3, 1, 0, 0, 5'h00, 32'h0, 5'h0d, 32'h6c0);
        step("coll.take", 1, 32'h600, 0, 32'h02, 32'h5a0, 0);

        // Reach isr = 3'b100, then reset mid-handler.
        drive(3'd3, 0, 1, 0, 5'h00, 32'h0, 5'h0d, 32'h0);
        step("rst.eret", 0, 32'h0, 1, 32'h10, 32'h6c0, 1);
        drive(3'd7, 0, 0, 0, 5'h00, 32'h0, 5'h0d, 32'h0);
        step("rst.rise2", 0, 32'h0, 0, 32'h00, 32'h6c0, 0);
        drive(3'd7, 1, 0, 0, 5'h00, 32'h0, 5'h0d, 32'h7e0);
        step("rst.take2", 1, 32'h400, 0, 32'h04, 32'h6c0, 0);
        drive(3'd7, 0, 0, 0, 5'h00, 32'h0, 5'h0d, 32'h0);
        step("rst.isr100", 0, 32'h0, 0, 32'h20, 32'h7e0, 1);

        rst = 1'b1;
        drive(3'd7, 0, 0, 0, 5'h00, 32'h0, 5'h0d, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(3'd7, 1, 0, 0, 5'h00, 32'h0, 5'h0d, 32'h900);
        step("post_rst.status", 0, 32'h0, 0, 32'h00, 32'h0, 1);
        drive(3'd7, 1, 0, 0, 5'h00, 32'h0, 5'h17, 32'h900);
        step("post_rst.mask", 0, 32'h0, 0, 32'h00, 32'h0, 1);
        drive(3'd7, 1, 0, 0, 5'h00, 32'h0, 5'h0e, 32'h900);
        step("post_rst.epc", 0, 32'h0, 0, 32'h00, 32'h0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cp0_int_ctrl.md
Name: cp0_int_ctrl

Overview:
- Coprocessor-0 interrupt controller for the 5-stage pipelined MIPS CPU.
- Edge-detects the 3 IO interrupt lines, holds the disable, mask and EPC registers, and keeps an in-service stack for nesting.
- Decides when the pipeline is redirected to a handler vector, and when `eret` returns to EPC.
- The CPU's ID-stage redirect mux consumes `int_take`/`int_vector` and `eret_redirect`/`epc_out`. The WB stage reads through the mfc0 port; the ID stage writes through the mtc0 port.

Parameters:
- VEC2, 32'h0000_0400, handler entry for irq[2] (highest priority)
- VEC1, 32'h0000_0600, handler entry for irq[1]
- VEC0, 32'h0000_0800, handler entry for irq[0] (lowest priority)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- irq_in  in  3  raw IO interrupt levels, already synchronous to clk
- take_ok  in  1  pipeline can accept a redirect this cycle (ID not paused, no branch redirect)
- pc_resume  in  32  address the interrupted flow resumes at (ID pc_next)
- eret  in  1  eret decoded in ID, 1-cycle qualified
- mtc0_we  in  1  cp0 write strobe
- mtc0_addr  in  5  cp0 write register number
- mtc0_data  in  32  cp0 write data
- mfc0_addr  in  5  cp0 read register number
- mfc0_data  out  32  cp0 read data, combinational
- int_take  out  1  1-cycle pulse: redirect PC to int_vector, flush ID
- int_vector  out  32  entry address, valid while int_take is high
- eret_redirect  out  1  1-cycle pulse: redirect PC to epc_out
- epc_out  out  32  current EPC register
- int_disable  out  1  current disable register

Behaviour:
- Reset values:
  - disable = 1; mask = 3'b000; epc = 0.
  - pending = 0; isr = 0; irq_prev = 0.
  - int_take = 0; eret_redirect = 0.
  - The in-service stack is cleared, even mid-handler.
- Edge detect:
  - irq_prev <= irq_in every cycle.
  - rise[i] = irq_in[i] & ~irq_prev[i] sets pending[i] on the next edge.
  - Levels held high do not re-trigger.
- Eligibility:
  - elig = pending & mask & {3{~disable}}.
  - Winner = highest set bit of elig (2 > 1 > 0).
  - The winner must be strictly higher than the highest set bit of isr (isr = 0 means any winner qualifies).
  - The winner is re-evaluated every cycle; it is never locked while waiting for take_ok.
- Take: when a qualifying winner exists, take_ok = 1 and eret = 0, the same cycle:
  - int_take = 1 combinationally.
  - int_vector = VEC of the winner.
  - At posedge: epc <= pc_resume, disable <= 1, pending[w] <= 0, isr[w] <= 1.
- Return: when eret = 1:
  - eret_redirect = 1 combinationally; epc_out supplies the target.
  - At posedge: the highest set bit of isr is cleared.
  - At posedge: disable <= 0 only if isr becomes 0 afterwards; otherwise disable <= 1.
  - eret with isr = 0 still redirects and sets disable <= 0.
- Nesting: handler software saves epc and writes disable = 0; a higher-priority winner then preempts and EPC is overwritten.
- FSM, derived from isr:
  - IDLE (isr = 0) -> SVC on take.
  - SVC -> SVC on nested take, or on eret with isr still nonzero.
  - SVC -> IDLE on eret leaving isr = 0.
- cp0 registers:
  - 0x16 disable, bit0.
  - 0x17 mask, bits[2:0].
  - 0x0e epc, 32 bits.
  - 0x0d status, read-only: {26'b0, isr[2:0], pending[2:0]}.
  - Writes to any other address are ignored; reads of any other address return 0.
- mfc0_data returns pre-write values when a read and a write hit the same register in the same cycle.
- Simultaneous events:
  - eret with a qualifying winner: eret wins; the take is deferred at least 1 cycle.
  - Take with an mtc0 to disable or epc: take's updates win.
  - eret with an mtc0 to disable: eret's update wins.
  - A rise on bit w in the same cycle as take of w: pending[w] stays 1.
  - mask = 0 or disable = 1: pending still accumulates; nothing is taken.

Decomposition:
- Shared package `cp0_pkg`:
  - Register numbers CP0_EPC = 5'h0e, CP0_STAT = 5'h0d, CP0_DIS = 5'h16, CP0_MASK = 5'h17.
  - Width constant NUM_IRQ = 3.
- One sub-module, `irq_prio_enc`: a 3-bit priority encoder producing the winner index, a valid flag, and the highest-set-bit index. It is instantiated twice, once on elig and once on isr.

Test Plan:
- Reset then rise irq_in = 3'b001, mask = 3'b001, disable = 0, take_ok = 1, pc_resume = 0x100 -> int_take pulse with int_vector = 0x800; next cycle epc = 0x100, disable = 1, status read (0x0d) = 0x08.
- pending = 3'b011, mask = 3'b111, disable = 0 -> take irq1 (vector 0x600); a second take does not occur until eret, after which irq0 is taken (vector 0x800).
- In the irq0 handler, mtc0 0x16 = 0, then rise irq2 -> nested take (vector 0x400), isr = 3'b101; first eret -> isr = 3'b001 and disable = 1; second eret -> isr = 0 and disable = 0.
- Qualifying winner with take_ok = 0 for 3 cycles -> no int_take; take_ok = 1 on the 4th cycle -> int_take that cycle with epc = that cycle's pc_resume.
- eret and a qualifying winner in the same cycle -> eret_redirect = 1 and int_take = 0; int_take occurs the next cycle.
- Assert rst while isr = 3'b100 -> next cycle isr = 0, disable = 1, mask = 0, epc = 0, and no outputs pulse.
